// File: rtl/mem_dep_store_queue.sv
// -----------------------------------------------------------------------------
// mem_dep_store_queue
//
// Purpose:
//   Circular queue of pending stores (start address + size code). Each cycle
//   one load probe is compared against every valid store for byte-range
//   overlap. The result is registered and reports whether any store overlaps
//   and, if so, the slot index of the youngest overlapping store. The load
//   issue logic stalls on res_dep until the conflicting store drains to the
//   D-cache.
//
// Ports:
//   clk        in   clock, rising-edge
//   clr        in   asynchronous active-low reset
//   flush      in   synchronous invalidate of all entries (highest priority)
//   enq_valid  in   allocate a store this cycle
//   enq_ready  out  queue can accept a store (~full)
//   enq_addr   in   store start byte address
//   enq_type   in   store size code: 0=1B 1=2B 2=4B 3=8B
//   deq        in   retire oldest entry
//   head_addr  out  oldest entry address (0 when empty)
//   head_type  out  oldest entry size code (0 when empty)
//   count      out  number of valid entries, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//   ld_valid   in   load probe this cycle
//   ld_addr    in   load start byte address
//   ld_type    in   load size code
//   res_valid  out  registered probe result valid
//   res_dep    out  probe overlapped at least one valid store
//   res_idx    out  slot of youngest overlapping store (0 if no dependency)
// -----------------------------------------------------------------------------
module mem_dep_store_queue #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [ADDR_W-1:0] enq_addr,
    input  logic [1:0]        enq_type,
    input  logic              deq,
    output logic [ADDR_W-1:0] head_addr,
    output logic [1:0]        head_type,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              empty,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_type,
    output logic              res_valid,
    output logic              res_dep,
    output logic [IDX_W-1:0]  res_idx
);

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    // Byte count of a size code, widened by one bit so range ends never wrap.
    function automatic logic [ADDR_W:0] sizeOf(input logic [1:0] sizeCode);
        return (ADDR_W+1)'(1) << sizeCode;
    endfunction

    // Entry storage (no reset needed: valid bits qualify every use)
    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic [1:0]        typeMem [DEPTH];

    logic [DEPTH-1:0]  validReg;
    logic [IDX_W-1:0]  headReg;
    logic [IDX_W-1:0]  tailReg;
    logic [IDX_W:0]    countReg;

    logic              resValidReg;
    logic              resDepReg;
    logic [IDX_W-1:0]  resIdxReg;

    logic              doEnq;
    logic              doDeq;
    logic              probeLive;

    logic [ADDR_W:0]   ldStart;
    logic [ADDR_W:0]   ldEnd;
    logic [DEPTH-1:0]  hitVec;
    logic              anyHit;
    logic [IDX_W-1:0]  hitIdx;
    logic [IDX_W-1:0]  walkSlot;

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    assign full      = (countReg == DEPTH_C);
    assign empty     = (countReg == '0);
    assign enq_ready = ~full;
    assign count     = countReg;

    assign head_addr = empty ? '0 : addrMem[headReg];
    assign head_type = empty ? '0 : typeMem[headReg];

    // Flush wins over enq/deq in the same cycle.
    assign doEnq     = enq_valid & ~full  & ~flush;
    assign doDeq     = deq       & ~empty & ~flush;
    assign probeLive = ld_valid  & ~flush;

    // ------------------------------------------------------------------
    // Per-slot overlap compare on half-open ranges [start, start+size).
    // Uses pre-edge contents, so a store enqueued this cycle is not seen,
    // while a store being dequeued this cycle still is.
    // ------------------------------------------------------------------
    assign ldStart = {1'b0, ld_addr};
    assign ldEnd   = ldStart + sizeOf(ld_type);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : genSlot
            logic [ADDR_W:0] stStart;
            logic [ADDR_W:0] stEnd;
            assign stStart    = {1'b0, addrMem[gi]};
            assign stEnd      = stStart + sizeOf(typeMem[gi]);
            assign hitVec[gi] = validReg[gi] & (ldStart < stEnd) & (stStart < ldEnd);
        end
    endgenerate

    // Youngest hit: walk backward from tail-1; the first hit found wins.
    // Valid entries are contiguous from head to tail-1, so invalid slots
    // reached by the walk simply never hit.
    always_comb begin
        anyHit   = 1'b0;
        hitIdx   = '0;
        walkSlot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            walkSlot = tailReg - IDX_W'(1) - IDX_W'(k);
            if (!anyHit && hitVec[walkSlot]) begin
                anyHit = 1'b1;
                hitIdx = walkSlot;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            validReg <= '0;
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
        end else if (flush) begin
            validReg <= '0;
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
        end else begin
            // Enq and deq never touch the same slot: enq needs ~full and
            // deq needs ~empty, so tail != head whenever both fire.
            if (doEnq) begin
                validReg[tailReg] <= 1'b1;
                tailReg           <= tailReg + IDX_W'(1);
            end
            if (doDeq) begin
                validReg[headReg] <= 1'b0;
                headReg           <= headReg + IDX_W'(1);
            end
            case ({doEnq, doDeq})
                2'b10:   countReg <= countReg + (IDX_W+1)'(1);
                2'b01:   countReg <= countReg - (IDX_W+1)'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    // Entry payload write
    always_ff @(posedge clk) begin
        if (doEnq) begin
            addrMem[tailReg] <= enq_addr;
            typeMem[tailReg] <= enq_type;
        end
    end

    // ------------------------------------------------------------------
    // Registered probe result; dep/idx are forced to 0 when not valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            resValidReg <= 1'b0;
            resDepReg   <= 1'b0;
            resIdxReg   <= '0;
        end else begin
            resValidReg <= probeLive;
            resDepReg   <= probeLive & anyHit;
            resIdxReg   <= (probeLive & anyHit) ? hitIdx : '0;
        end
    end

    assign res_valid = resValidReg;
    assign res_dep   = resDepReg;
    assign res_idx   = resIdxReg;

endmodule

// File: tb/tb_mem_dep_store_queue.sv
module tb_mem_dep_store_queue;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int IDX_W  = 2;

    logic              clk = 1'b0;
    logic              clr;
    logic              flush;
    logic              enq_valid;
    logic              enq_ready;
    logic [ADDR_W-1:0] enq_addr;
    logic [1:0]        enq_type;
    logic              deq;
    logic [ADDR_W-1:0] head_addr;
    logic [1:0]        head_type;
    logic [IDX_W:0]    count;
    logic              full;
    logic              empty;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_type;
    logic              res_valid;
    logic              res_dep;
    logic [IDX_W-1:0]  res_idx;

    int passed = 0;
    int total  = 0;

    mem_dep_store_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_addr  (enq_addr),
        .enq_type  (enq_type),
        .deq       (deq),
        .head_addr (head_addr),
        .head_type (head_type),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_type   (ld_type),
        .res_valid (res_valid),
        .res_dep   (res_dep),
        .res_idx   (res_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %-24s observed=0x%0h expected=0x%0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_addr  = '0;
        enq_type  = '0;
        deq       = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_type   = '0;
    endtask

    // Advance one clock with whatever inputs are set, then return to idle
    // 1 time unit after the edge so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic enq(input logic [ADDR_W-1:0] a, input logic [1:0] t);
        enq_valid = 1'b1;
        enq_addr  = a;
        enq_type  = t;
        step();
    endtask

    task automatic probe(input logic [ADDR_W-1:0] a, input logic [1:0] t);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_type  = t;
        step();
    endtask

    task automatic doFlush();
        flush = 1'b1;
        step();
    endtask

    initial begin
        idle();
        clr = 1'b0;
        #3;
        // Reset state
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_empty",     64'(empty),     64'd1);
        chk("rst_full",      64'(full),      64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_head_addr", 64'(head_addr), 64'd0);
        #1 clr = 1'b1;

        // ---- Reset mid-operation ----
        enq(32'h10, 2'd0);
        enq(32'h20, 2'd0);
        enq_valid = 1'b1; enq_addr = 32'h30; enq_type = 2'd0;
        ld_valid  = 1'b1; ld_addr  = 32'h10; ld_type  = 2'd0;
        step();
        chk("mid_count3",    64'(count),     64'd3);
        chk("mid_head_addr", 64'(head_addr), 64'h10);
        chk("mid_res_valid", 64'(res_valid), 64'd1);
        chk("mid_res_dep",   64'(res_dep),   64'd1);
        #2 clr = 1'b0;
        #1;
        chk("clr_count",     64'(count),     64'd0);
        chk("clr_empty",     64'(empty),     64'd1);
        chk("clr_res_valid", 64'(res_valid), 64'd0);
        chk("clr_res_dep",   64'(res_dep),   64'd0);
        chk("clr_head_addr", 64'(head_addr), 64'd0);
        #1 clr = 1'b1;

        // ---- Overlap edges: store [0x4000,0x4004) ----
        enq(32'h4000, 2'd2);
        chk("ov_head_type",  64'(head_type), 64'd2);
        probe(32'h4003, 2'd0);
        chk("ov_4003_valid", 64'(res_valid), 64'd1);
        chk("ov_4003_dep",   64'(res_dep),   64'd1);
        chk("ov_4003_idx",   64'(res_idx),   64'd0);
        probe(32'h4004, 2'd3);
        chk("ov_4004_valid", 64'(res_valid), 64'd1);
        chk("ov_4004_dep",   64'(res_dep),   64'd0);
        probe(32'h3FFC, 2'd2);
        chk("ov_3ffc_dep",   64'(res_dep),   64'd0);
        probe(32'h3FFD, 2'd2);
        chk("ov_3ffd_dep",   64'(res_dep),   64'd1);
        step();
        chk("ov_idle_valid", 64'(res_valid), 64'd0);
        deq = 1'b1;
        step();
        chk("ov_deq_count",  64'(count),     64'd0);
        deq = 1'b1;
        step();
        chk("deq_empty_cnt", 64'(count),     64'd0);

        // ---- Youngest select ----
        doFlush();
        enq(32'h100, 2'd3);
        enq(32'h200, 2'd0);
        enq(32'h104, 2'd2);
        probe(32'h104, 2'd0);
        chk("yg_dep",        64'(res_dep),   64'd1);
        chk("yg_idx",        64'(res_idx),   64'd2);
        probe(32'h200, 2'd0);
        chk("yg_idx_200",    64'(res_idx),   64'd1);

        // ---- Wrap / full ----
        doFlush();
        enq(32'h1000, 2'd0);
        enq(32'h1100, 2'd0);
        enq(32'h1200, 2'd0);
        enq(32'h1300, 2'd0);
        chk("wr_full",       64'(full),      64'd1);
        chk("wr_enq_ready",  64'(enq_ready), 64'd0);
        chk("wr_count4",     64'(count),     64'd4);
        enq(32'h9000, 2'd0);
        chk("wr_drop_count", 64'(count),     64'd4);
        chk("wr_drop_head",  64'(head_addr), 64'h1000);
        probe(32'h9000, 2'd0);
        chk("wr_drop_dep",   64'(res_dep),   64'd0);
        deq = 1'b1; step();
        deq = 1'b1; step();
        chk("wr_deq_count",  64'(count),     64'd2);
        chk("wr_deq_head",   64'(head_addr), 64'h1200);
        enq(32'h1200, 2'd0);
        enq(32'h1200, 2'd2);
        chk("wr_refill_cnt", 64'(count),     64'd4);
        chk("wr_refill_full",64'(full),      64'd1);
        probe(32'h1200, 2'd0);
        chk("wr_yg_dep",     64'(res_dep),   64'd1);
        chk("wr_yg_idx",     64'(res_idx),   64'd1);

        // ---- Same-cycle events ----
        doFlush();
        enq_valid = 1'b1; enq_addr = 32'h500; enq_type = 2'd0;
        ld_valid  = 1'b1; ld_addr  = 32'h500; ld_type  = 2'd0;
        step();
        chk("sc_enq_valid",  64'(res_valid), 64'd1);
        chk("sc_enq_dep",    64'(res_dep),   64'd0);
        chk("sc_enq_count",  64'(count),     64'd1);
        deq      = 1'b1;
        ld_valid = 1'b1; ld_addr = 32'h500; ld_type = 2'd0;
        step();
        chk("sc_deq_dep",    64'(res_dep),   64'd1);
        chk("sc_deq_idx",    64'(res_idx),   64'd0);
        chk("sc_deq_count",  64'(count),     64'd0);
        enq(32'h600, 2'd0);
        flush    = 1'b1;
        ld_valid = 1'b1; ld_addr = 32'h600; ld_type = 2'd0;
        step();
        chk("sc_flush_valid",64'(res_valid), 64'd0);
        chk("sc_flush_dep",  64'(res_dep),   64'd0);

        // ---- Top of address space ----
        enq(32'hFFFF_FFF8, 2'd3);
        probe(32'h0000_0000, 2'd3);
        chk("top_zero_valid",64'(res_valid), 64'd1);
        chk("top_zero_dep",  64'(res_dep),   64'd0);
        probe(32'hFFFF_FFFF, 2'd0);
        chk("top_ff_dep",    64'(res_dep),   64'd1);
        chk("top_ff_idx",    64'(res_idx),   64'd0);
        enq_valid = 1'b1; enq_addr = 32'h10; enq_type = 2'd1;
        deq       = 1'b1;
        step();
        chk("encdeq_count",  64'(count),     64'd1);
        chk("encdeq_head",   64'(head_addr), 64'h10);
        chk("encdeq_htype",  64'(head_type), 64'd1);
        flush     = 1'b1;
        enq_valid = 1'b1; enq_addr = 32'h20; enq_type = 2'd0;
        step();
        chk("fl_enq_count",  64'(count),     64'd0);
        chk("fl_enq_empty",  64'(empty),     64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
